// File: rtl/fifo_rr_write_arbiter_if.sv
// Producer/FIFO-side bundle of the round-robin write arbiter.
// Latency: none (wires only); rq_ack is combinational, fo_* are registered in the arbiter.
// Backpressure: ff_busy/ff_error from the FIFO gate every accept; producers hold rq_stb/rq_dat until acked.
interface fifo_rr_write_arbiter_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int TAGW    = 2
);
  logic [NUM_REQ-1:0]       rq_stb;
  logic [NUM_REQ*WIDTH-1:0] rq_dat;
  logic [NUM_REQ-1:0]       rq_ack;
  logic                     fo_stb;
  logic [WIDTH+TAGW-1:0]    fo_dat;
  logic                     ff_busy;
  logic                     ff_error;
  logic                     clr;
  logic                     err;
  logic [TAGW-1:0]          grant_idx;

  // Arbiter side
  modport slave (
    input  rq_stb, rq_dat, ff_busy, ff_error, clr,
    output rq_ack, fo_stb, fo_dat, err, grant_idx
  );

  // Environment side (producers, FIFO, software)
  modport master (
    output rq_stb, rq_dat, ff_busy, ff_error, clr,
    input  rq_ack, fo_stb, fo_dat, err, grant_idx
  );
endinterface

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bounded bursts, tagged words.
// Latency: rq_ack same cycle as rq_stb; fo_stb/fo_dat registered, 1 cycle after the accept.
// Backpressure: ff_busy stalls without breaking a burst; ff_error locks out all writes until clr.
module fifo_rr_write_arbiter #(
  parameter int WIDTH     = 16,
  parameter int NUM_REQ   = 4,
  parameter int TAGW      = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                   fi_clk,
  input  logic                   fi_rst,
  fifo_rr_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, HALT} state_t;

  state_t                state_q, state_d;
  logic [TAGW-1:0]       ptr_q, ptr_d;
  logic [TAGW-1:0]       owner_q, owner_d;
  logic [7:0]            burst_cnt_q, burst_cnt_d;
  logic                  fo_stb_q, fo_stb_d;
  logic [WIDTH+TAGW-1:0] fo_dat_q, fo_dat_d;
  logic                  err_q, err_d;
  logic [TAGW-1:0]       grant_idx_q, grant_idx_d;

  logic [TAGW-1:0]       owner_nxt;
  logic [TAGW-1:0]       scan_start;
  logic [TAGW-1:0]       sel;
  logic                  sel_vld;
  logic                  keep_owner;
  logic                  open_ok;
  logic                  accept;
  int                    scan_idx;

  // Owner successor, wrapping correctly for non-power-of-2 NUM_REQ
  assign owner_nxt = (owner_q == TAGW'(NUM_REQ - 1)) ? '0 : owner_q + TAGW'(1);

  // Winner selection: keep the owner while its burst lasts, else rotating first-hit scan
  always_comb begin
    sel        = '0;
    sel_vld    = 1'b0;
    keep_owner = 1'b0;
    scan_idx   = 0;
    open_ok    = (state_q != HALT) && !bus.ff_busy && !bus.ff_error && !fi_rst;
    scan_start = (state_q == GRANT) ? owner_nxt : ptr_q;
    if (state_q == GRANT && bus.rq_stb[owner_q] && burst_cnt_q < 8'(MAX_BURST)) begin
      keep_owner = 1'b1;
      sel_vld    = 1'b1;
      sel        = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = int'(scan_start) + k;
        if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
        if (!sel_vld && bus.rq_stb[scan_idx]) begin
          sel_vld = 1'b1;
          sel     = TAGW'(scan_idx);
        end
      end
    end
  end

  assign accept     = open_ok && sel_vld;
  assign bus.rq_ack = accept ? (NUM_REQ'(1) << sel) : '0;

  // Next-state: error lockout has priority, busy freezes arbitration state
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    err_d       = err_q;
    fo_stb_d    = accept;
    fo_dat_d    = fo_dat_q;
    grant_idx_d = grant_idx_q;
    if (accept) begin
      fo_dat_d    = {sel, bus.rq_dat[int'(sel)*WIDTH +: WIDTH]};
      grant_idx_d = sel;
    end
    if (bus.ff_error) begin
      state_d = HALT;
      err_d   = 1'b1;
    end else if (state_q == HALT) begin
      if (bus.clr) begin
        state_d     = IDLE;
        err_d       = 1'b0;
        burst_cnt_d = '0;
      end
    end else begin
      if (bus.clr) err_d = 1'b0;
      if (!bus.ff_busy) begin
        // A burst that did not continue hands priority to the next index
        if (state_q == GRANT && !keep_owner) ptr_d = owner_nxt;
        if (accept) begin
          if (keep_owner) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end else begin
            owner_d     = sel;
            burst_cnt_d = 8'd1;
            state_d     = GRANT;
          end
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  // State and output registers; reset discards any pending write
  always_ff @(posedge fi_clk) begin
    if (fi_rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      fo_stb_q    <= 1'b0;
      fo_dat_q    <= '0;
      err_q       <= 1'b0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      fo_stb_q    <= fo_stb_d;
      fo_dat_q    <= fo_dat_d;
      err_q       <= err_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign bus.fo_stb    = fo_stb_q;
  assign bus.fo_dat    = fo_dat_q;
  assign bus.err       = err_q;
  assign bus.grant_idx = grant_idx_q;

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Randomized bench for the round-robin write arbiter against a queue-level reference model.
// Latency: checks rq_ack in the request cycle and fo_* one cycle later.
// Backpressure: random ff_busy, ff_error pulses, clr and mid-burst resets.
module tb_fifo_rr_write_arbiter;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int TW = 2;
  localparam int MB = 4;
  localparam int S_IDLE  = 0;
  localparam int S_GRANT = 1;
  localparam int S_HALT  = 2;

  logic clk = 1'b0;
  logic rst;

  fifo_rr_write_arbiter_if #(.WIDTH(W), .NUM_REQ(N), .TAGW(TW)) bus ();

  fifo_rr_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .TAGW(TW), .MAX_BURST(MB)) dut (
    .fi_clk (clk),
    .fi_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int              m_state, m_ptr, m_owner, m_cnt, m_gidx;
  logic            m_fo_stb, m_err;
  logic [W+TW-1:0] m_fo_dat;

  // Producer state and knobs
  logic [N-1:0] stb;
  logic [W-1:0] dat [N];
  int           seq [N];
  logic [N-1:0] prev_ack, exp_ack, mask;
  int p_req, p_drop, p_busy, p_err, p_clr, p_rst;
  bit force_rst, armed, record;
  int tag_q[$];
  logic [W-1:0] pay_q[$];

  // One arbitration step of the model: returns the accept vector, advances registered state
  task automatic model_step(input logic r, input logic [N-1:0] s, input logic busy,
                            input logic er, input logic cl, output logic [N-1:0] ack);
    int sel, start;
    bit cont;
    logic [TW-1:0] tag;
    ack  = '0;
    sel  = -1;
    cont = 0;
    if (r) begin
      m_state = S_IDLE; m_ptr = 0; m_owner = 0; m_cnt = 0;
      m_fo_stb = 1'b0; m_fo_dat = '0; m_err = 1'b0; m_gidx = 0;
      return;
    end
    if (m_state != S_HALT && !busy && !er) begin
      if (m_state == S_GRANT && s[m_owner] && m_cnt < MB) begin
        sel = m_owner;
        cont = 1;
      end else begin
        start = (m_state == S_GRANT) ? (m_owner + 1) % N : m_ptr;
        for (int k = 0; k < N; k++)
          if (sel < 0 && s[(start + k) % N]) sel = (start + k) % N;
      end
    end
    m_fo_stb = (sel >= 0);
    if (sel >= 0) begin
      ack[sel] = 1'b1;
      tag = sel[TW-1:0];
      m_fo_dat = {tag, dat[sel]};
      m_gidx = sel;
    end
    if (er) begin
      m_state = S_HALT;
      m_err = 1'b1;
    end else if (m_state == S_HALT) begin
      if (cl) begin
        m_state = S_IDLE;
        m_err = 1'b0;
        m_cnt = 0;
      end
    end else begin
      if (cl) m_err = 1'b0;
      if (!busy) begin
        if (m_state == S_GRANT && !cont) m_ptr = (m_owner + 1) % N;
        if (sel >= 0) begin
          if (cont) m_cnt++;
          else begin
            m_owner = sel;
            m_cnt = 1;
            m_state = S_GRANT;
          end
        end else begin
          m_state = S_IDLE;
        end
      end
    end
  endtask

  task automatic run_cycles(input int n);
    logic b, e, c, r;
    for (int cy = 0; cy < n; cy++) begin
      @(negedge clk);
      if (armed) begin
        chk("fo_stb", 32'(bus.fo_stb), 32'(m_fo_stb));
        chk("fo_dat", 32'(bus.fo_dat), 32'(m_fo_dat));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("grant_idx", 32'(bus.grant_idx), 32'(m_gidx));
        if (record && bus.fo_stb === 1'b1) begin
          tag_q.push_back(int'(bus.fo_dat[W+TW-1:W]));
          pay_q.push_back(bus.fo_dat[W-1:0]);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (prev_ack[i]) stb[i] = 1'b0;
        else if (stb[i] && int'($urandom_range(99)) < p_drop) stb[i] = 1'b0;
        if (!mask[i]) stb[i] = 1'b0;
        else if (!stb[i] && int'($urandom_range(99)) < p_req) begin
          stb[i] = 1'b1;
          dat[i] = W'(16'h1000 + i * 256 + seq[i]);
          seq[i]++;
        end
        bus.rq_dat[i*W +: W] = dat[i];
      end
      b = (int'($urandom_range(99)) < p_busy);
      e = (int'($urandom_range(99)) < p_err);
      c = (int'($urandom_range(99)) < p_clr);
      r = force_rst || (int'($urandom_range(99)) < p_rst);
      bus.rq_stb   = stb;
      bus.ff_busy  = b;
      bus.ff_error = e;
      bus.clr      = c;
      rst          = r;
      #1;
      model_step(r, stb, b, e, c, exp_ack);
      chk("rq_ack", 32'(bus.rq_ack), 32'(exp_ack));
      prev_ack = exp_ack;
      if (r) armed = 1;
    end
  endtask

  initial begin
    stb = '0; prev_ack = '0; armed = 0; record = 0;
    for (int i = 0; i < N; i++) begin dat[i] = '0; seq[i] = 0; end
    bus.rq_stb = '0; bus.rq_dat = '0; bus.ff_busy = 1'b0; bus.ff_error = 1'b0; bus.clr = 1'b0;
    rst = 1'b1;

    // Phase 1: all four stream continuously from reset, no backpressure
    mask = 4'b1111; p_req = 100; p_drop = 0; p_busy = 0; p_err = 0; p_clr = 0; p_rst = 0;
    force_rst = 1;
    run_cycles(2);
    force_rst = 0;
    record = 1;
    run_cycles(40);
    record = 0;
    // Bursts of MB words per requester, rotating 0,1,2,3,0..., payloads consecutive
    begin
      int cnt [N];
      for (int i = 0; i < N; i++) cnt[i] = 0;
      chk("p1_nwords", 32'(tag_q.size() >= 32), 32'd1);
      for (int k = 0; k < 32 && k < tag_q.size(); k++) begin
        chk("p1_tag", 32'(tag_q[k]), 32'((k / MB) % N));
        chk("p1_pay", 32'(pay_q[k]), 32'(16'h1000 + tag_q[k] * 256 + cnt[tag_q[k]]));
        cnt[tag_q[k]]++;
      end
    end

    // Phase 2: only requester 2, re-granted across burst boundaries
    mask = 4'b0100;
    run_cycles(60);

    // Phase 3: random requests with busy stalls
    mask = 4'b1111; p_req = 70; p_busy = 20;
    run_cycles(300);

    // Phase 4: drops, error lockout and clears
    p_drop = 10; p_busy = 10; p_err = 3; p_clr = 20;
    run_cycles(400);

    // Phase 5: everything, plus mid-burst resets
    p_req = 80; p_rst = 3;
    run_cycles(400);

    // Final reset cycle: outputs must return to their reset values
    force_rst = 1;
    run_cycles(1);
    force_rst = 0;
    p_err = 0; p_rst = 0;
    run_cycles(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
